dma_2d_load_engine: RTL

- Parametrised successor to the single-row TPC DMA load path.
- Accepts one 128-bit DMA command and moves a strided 2-D tile (rows × cols beats) from external memory into TPC SRAM.
- Each row is split into AXI4 INCR read bursts of at most MAX_BURST beats, with up to MAX_OUTSTANDING bursts in flight.
- Sits between the TPC command decoder (DMA slot) and the AXI master port / SRAM write port.

---
 rtl/dma_2d_load_engine.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/dma_2d_load_engine.sv
// Strided 2-D tile loader: AXI4 INCR read bursts into TPC SRAM.
// Optional DMA_PERF_CNT_EN adds perf_cycles / perf_beats counters.
module dma_2d_load_engine #(
    parameter int AXI_ADDR_WIDTH  = 40,
    parameter int DATA_WIDTH      = 256,
    parameter int ID_WIDTH        = 4,
    parameter int AXI_ID          = 0,
    parameter int SRAM_ADDR_WIDTH = 20,
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [127:0]               cmd,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [ID_WIDTH-1:0]        m_axi_arid,
    output logic [AXI_ADDR_WIDTH-1:0]  m_axi_araddr,
    output logic [7:0]                 m_axi_arlen,
    output logic [2:0]                 m_axi_arsize,
    output logic [1:0]                 m_axi_arburst,
    output logic                       m_axi_arvalid,
    input  logic                       m_axi_arready,
    input  logic [ID_WIDTH-1:0]        m_axi_rid,
    input  logic [DATA_WIDTH-1:0]      m_axi_rdata,
    input  logic [1:0]                 m_axi_rresp,
    input  logic                       m_axi_rlast,
    input  logic                       m_axi_rvalid,
    output logic                       m_axi_rready,
    output logic                       sram_we,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0]      sram_wdata
`ifdef DMA_PERF_CNT_EN
    ,
    output logic [31:0]                perf_cycles,
    output logic [31:0]                perf_beats
`endif
);

    localparam int BPB  = DATA_WIDTH / 8;
    localparam int OFFB = $clog2(BPB);
    localparam int OCW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW   = SRAM_ADDR_WIDTH + OFFB;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                    state;
    logic [11:0]               rows_q, cols_q, estr_q, istr_q;
    logic [11:0]               ar_row, ar_col;
    logic [AXI_ADDR_WIDTH-1:0] ar_base;
    logic                      ar_done;
    logic [11:0]               r_row, r_col;
    logic [7:0]                r_bcnt;
    logic [SW-1:0]             r_base;
    logic                      r_done;
    logic [OCW-1:0]            out_cnt;

    logic        ar_hs, r_beat_hs, r_hs, r_exp_last, issue, cmd_bad, cmd_empty;
    logic [12:0] ar_rem, ar_chunk, ar_next;
    logic        unused;

    assign m_axi_arid    = ID_WIDTH'(AXI_ID);
    assign m_axi_arsize  = 3'(OFFB);
    assign m_axi_arburst = 2'b01;

    assign ar_hs      = m_axi_arvalid && m_axi_arready;
    assign r_beat_hs  = m_axi_rvalid && m_axi_rready;
    assign r_hs       = r_beat_hs && !r_done;
    assign r_exp_last = (r_col == cols_q - 12'd1)
                     || (r_bcnt == 8'(MAX_BURST - 1));
    assign ar_rem     = {1'b0, cols_q} - {1'b0, ar_col};
    assign ar_chunk   = (ar_rem > 13'(MAX_BURST)) ? 13'(MAX_BURST) : ar_rem;
    assign ar_next    = {1'b0, ar_col} + ar_chunk;
    assign issue      = (state == S_RUN) && !m_axi_arvalid && !ar_done
                     && (out_cnt < OCW'(MAX_OUTSTANDING));
    assign cmd_bad    = cmd[119:112] != 8'h01;
    assign cmd_empty  = cmd[51:40] == 12'd0 || cmd[39:28] == 12'd0;
    assign unused     = ^{cmd[127:120], cmd[3:0], m_axi_rid};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cmd_ready     <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            sram_we       <= 1'b0;
            sram_addr     <= '0;
            sram_wdata    <= '0;
            rows_q        <= '0;
            cols_q        <= '0;
            estr_q        <= '0;
            istr_q        <= '0;
            ar_row        <= '0;
            ar_col        <= '0;
            ar_base       <= '0;
            ar_done       <= 1'b0;
            r_row         <= '0;
            r_col         <= '0;
            r_bcnt        <= '0;
            r_base        <= '0;
            r_done        <= 1'b0;
            out_cnt       <= '0;
        end else begin
            unique case (state)
                S_IDLE: if (cmd_valid) begin
                    rows_q    <= cmd[51:40];
                    cols_q    <= cmd[39:28];
                    estr_q    <= cmd[27:16];
                    istr_q    <= cmd[15:4];
                    ar_base   <= AXI_ADDR_WIDTH'(cmd[111:72]);
                    r_base    <= SW'(cmd[71:52]);
                    ar_row    <= '0;
                    ar_col    <= '0;
                    ar_done   <= 1'b0;
                    r_row     <= '0;
                    r_col     <= '0;
                    r_bcnt    <= '0;
                    r_done    <= 1'b0;
                    out_cnt   <= '0;
                    cmd_ready <= 1'b0;
                    busy      <= 1'b1;
                    error     <= cmd_bad;
                    if (cmd_bad || cmd_empty) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state        <= S_RUN;
                        m_axi_rready <= 1'b1;
                    end
                end
                S_RUN: if (ar_done && r_done) begin
                    state        <= S_DONE;
                    done         <= 1'b1;
                    m_axi_rready <= 1'b0;
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase

            // AR generator: fields stay frozen while arvalid waits
            if (ar_hs) begin
                m_axi_arvalid <= 1'b0;
            end else if (issue) begin
                m_axi_arvalid <= 1'b1;
                m_axi_araddr  <= ar_base + (AXI_ADDR_WIDTH'(ar_col) << OFFB);
                m_axi_arlen   <= 8'(ar_chunk - 13'd1);
                if (ar_next >= {1'b0, cols_q}) begin
                    ar_col  <= '0;
                    ar_row  <= ar_row + 12'd1;
                    ar_base <= ar_base + AXI_ADDR_WIDTH'(estr_q);
                    if (ar_row == rows_q - 12'd1) ar_done <= 1'b1;
                end else begin
                    ar_col <= ar_next[11:0];
                end
            end

            // Burst completion is tracked on the expected last beat
            unique case ({ar_hs, r_hs && r_exp_last})
                2'b10:   out_cnt <= out_cnt + OCW'(1);
                2'b01:   out_cnt <= out_cnt - OCW'(1);
                default: out_cnt <= out_cnt;
            endcase

            sram_we <= r_hs;
            if (r_hs) begin
                sram_addr  <= r_base[SW-1:OFFB] + SRAM_ADDR_WIDTH'(r_col);
                sram_wdata <= m_axi_rdata;
                if (m_axi_rresp != 2'b00 || m_axi_rlast != r_exp_last)
                    error <= 1'b1;
                r_bcnt <= r_exp_last ? 8'd0 : r_bcnt + 8'd1;
                if (r_col == cols_q - 12'd1) begin
                    r_col  <= '0;
                    r_row  <= r_row + 12'd1;
                    r_base <= r_base + SW'(istr_q);
                    if (r_row == rows_q - 12'd1) r_done <= 1'b1;
                end else begin
                    r_col <= r_col + 12'd1;
                end
            end
        end
    end

`ifdef DMA_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles <= '0;
            perf_beats  <= '0;
        end else if (state == S_IDLE && cmd_valid) begin
            perf_cycles <= '0;
            perf_beats  <= '0;
        end else begin
            if (state == S_RUN) perf_cycles <= perf_cycles + 32'd1;
            if (r_beat_hs)      perf_beats  <= perf_beats + 32'd1;
        end
    end
`endif

endmodule
